// File: rtl/fft_pkg.sv
// Shared types for the streaming FFT: FSM states, complex Q1.15 twiddle type,
// 64-point twiddle ROM (cos, -sin) and a bit-reverse helper.
package fft_pkg;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_q15_t;

  localparam int TW_ROM_N = 32;

  // Entry 0 holds 32767 in place of +1.0; index 0 is bypassed in the butterfly anyway.
  localparam logic signed [15:0] TW_COS [TW_ROM_N] = '{
    16'sd32767,  16'sd32610,  16'sd32138,  16'sd31357,
    16'sd30274,  16'sd28899,  16'sd27246,  16'sd25330,
    16'sd23170,  16'sd20788,  16'sd18205,  16'sd15447,
    16'sd12540,  16'sd9512,   16'sd6393,   16'sd3212,
    16'sd0,     -16'sd3212,  -16'sd6393,  -16'sd9512,
   -16'sd12540, -16'sd15447, -16'sd18205, -16'sd20788,
   -16'sd23170, -16'sd25330, -16'sd27246, -16'sd28899,
   -16'sd30274, -16'sd31357, -16'sd32138, -16'sd32610
  };

  localparam logic signed [15:0] TW_NSIN [TW_ROM_N] = '{
    16'sd0,     -16'sd3212,  -16'sd6393,  -16'sd9512,
   -16'sd12540, -16'sd15447, -16'sd18205, -16'sd20788,
   -16'sd23170, -16'sd25330, -16'sd27246, -16'sd28899,
   -16'sd30274, -16'sd31357, -16'sd32138, -16'sd32610,
    16'sh8000,  -16'sd32610, -16'sd32138, -16'sd31357,
   -16'sd30274, -16'sd28899, -16'sd27246, -16'sd25330,
   -16'sd23170, -16'sd20788, -16'sd18205, -16'sd15447,
   -16'sd12540, -16'sd9512,  -16'sd6393,  -16'sd3212
  };

  function automatic cplx_q15_t tw_rom(input logic [4:0] k);
    cplx_q15_t w;
    w.re = TW_COS[k];
    w.im = TW_NSIN[k];
    return w;
  endfunction

  function automatic logic [5:0] bit_rev(input logic [5:0] v, input int bits);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < bits) r[3'(i)] = v[3'(bits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly: t = W*b, x = a+t, y = a-t.
// Macro FFT_STAGE_SCALE_EN halves both outputs (floor) so a full transform scales by 1/N.
module fft_bfly #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic signed [DATA_W-1:0] a_re_i,
  input  logic signed [DATA_W-1:0] a_im_i,
  input  logic signed [DATA_W-1:0] b_re_i,
  input  logic signed [DATA_W-1:0] b_im_i,
  input  logic signed [TW_W-1:0]   w_re_i,
  input  logic signed [TW_W-1:0]   w_im_i,
  input  logic                     bypass_i,
  output logic signed [DATA_W-1:0] x_re_o,
  output logic signed [DATA_W-1:0] x_im_o,
  output logic signed [DATA_W-1:0] y_re_o,
  output logic signed [DATA_W-1:0] y_im_o
);

  localparam int PW = DATA_W + TW_W + 1;

  logic signed [PW-1:0]     br, bi, wr, wi, p_re, p_im;
  logic signed [DATA_W-1:0] t_re, t_im;
`ifdef FFT_STAGE_SCALE_EN
  logic signed [DATA_W:0]   s_re, s_im, d_re, d_im;
`endif

  always_comb begin
    br   = PW'(b_re_i);
    bi   = PW'(b_im_i);
    wr   = PW'(w_re_i);
    wi   = PW'(w_im_i);
    p_re = br * wr - bi * wi;
    p_im = br * wi + bi * wr;
    if (bypass_i) begin
      t_re = b_re_i;
      t_im = b_im_i;
    end else begin
      t_re = DATA_W'(p_re >>> (TW_W - 1));
      t_im = DATA_W'(p_im >>> (TW_W - 1));
    end
`ifdef FFT_STAGE_SCALE_EN
    // Sum kept one bit wider so the halving cannot overflow.
    s_re   = (DATA_W+1)'(a_re_i) + (DATA_W+1)'(t_re);
    s_im   = (DATA_W+1)'(a_im_i) + (DATA_W+1)'(t_im);
    d_re   = (DATA_W+1)'(a_re_i) - (DATA_W+1)'(t_re);
    d_im   = (DATA_W+1)'(a_im_i) - (DATA_W+1)'(t_im);
    x_re_o = DATA_W'(s_re >>> 1);
    x_im_o = DATA_W'(s_im >>> 1);
    y_re_o = DATA_W'(d_re >>> 1);
    y_im_o = DATA_W'(d_im >>> 1);
`else
    x_re_o = a_re_i + t_re;
    x_im_o = a_im_i + t_im;
    y_re_o = a_re_i - t_re;
    y_im_o = a_im_i - t_im;
`endif
  end

endmodule

// File: rtl/fft_stream.sv
// Streaming in-place radix-2 FFT: load N samples (bit-reversed), one butterfly per
// cycle, unload bins in natural order. Optional per-stage scaling via FFT_STAGE_SCALE_EN.
module fft_stream
  import fft_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int N = 1 << LOG2N;

  state_e             state_q, state_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [2:0]         stage_q, stage_d;
  logic signed [DATA_W-1:0] mem_re_q [N];
  logic signed [DATA_W-1:0] mem_im_q [N];

  logic [LOG2N-1:0]   one_s, mask_s, j_w, ia, ib, ld_addr;
  logic [4:0]         rom_idx;
  cplx_q15_t          tw;
  logic signed [31:0] c32, s32;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [DATA_W-1:0] x_re, x_im, y_re, y_im;

  // Butterfly addressing: j is the position within a group, twiddle k = j*N/2^(s+1).
  always_comb begin
    one_s   = LOG2N'(1) << stage_q;
    mask_s  = one_s - LOG2N'(1);
    j_w     = cnt_q & mask_s;
    ia      = ((cnt_q & ~mask_s) << 1) | j_w;
    ib      = ia | one_s;
    rom_idx = 5'(j_w) << (3'd5 - stage_q);
    tw      = tw_rom(rom_idx);
    c32     = {tw.re, 16'h0000};
    s32     = {tw.im, 16'h0000};
    w_re    = TW_W'(c32 >>> (32 - TW_W));
    w_im    = TW_W'(s32 >>> (32 - TW_W));
    ld_addr = LOG2N'(bit_rev(6'(cnt_q), LOG2N));
  end

  fft_bfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bfly (
    .a_re_i   (mem_re_q[ia]),
    .a_im_i   (mem_im_q[ia]),
    .b_re_i   (mem_re_q[ib]),
    .b_im_i   (mem_im_q[ib]),
    .w_re_i   (w_re),
    .w_im_i   (w_im),
    .bypass_i (j_w == '0),
    .x_re_o   (x_re),
    .x_im_o   (x_im),
    .y_re_o   (y_re),
    .y_im_o   (y_im)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          if (cnt_q == LOG2N'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (cnt_q == LOG2N'(N / 2 - 1)) begin
          cnt_d = '0;
          if (stage_q == 3'(LOG2N - 1)) begin
            stage_d = '0;
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == LOG2N'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Register file is not reset; a new frame overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid && in_ready) begin
      mem_re_q[ld_addr] <= in_re;
      mem_im_q[ld_addr] <= in_im;
    end else if (state_q == S_COMPUTE && !rst) begin
      mem_re_q[ia] <= x_re;
      mem_im_q[ia] <= x_im;
      mem_re_q[ib] <= y_re;
      mem_im_q[ib] <= y_im;
    end
  end

  assign in_ready  = (state_q == S_LOAD) && !rst;
  assign out_valid = (state_q == S_UNLOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_re    = out_valid ? mem_re_q[cnt_q] : '0;
  assign out_im    = out_valid ? mem_im_q[cnt_q] : '0;
  assign out_idx   = out_valid ? cnt_q : '0;
  assign out_last  = out_valid && (cnt_q == LOG2N'(N - 1));

endmodule

// File: tb/tb_fft_stream.sv
// Scoreboard bench for fft_stream (N=8): directed frames with hand-computed bins,
// backpressure, ignored in_valid while busy, and abort by reset mid-compute.
module tb_fft_stream;

  localparam int N = 8;
`ifdef FFT_STAGE_SCALE_EN
  localparam int IMP_RE = 125, CONST_X0 = 100, IMAG_IM = 62, WRAP_X0 = 20000;
`else
  localparam int IMP_RE = 1000, CONST_X0 = 800, IMAG_IM = 500, WRAP_X0 = 28928;
`endif

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [15:0] in_re, in_im, out_re, out_im;
  logic [2:0] out_idx;

  fft_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; int re; int im; int tol; } exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, first_acc = -1, first_out = -1;
  int fr_re[N], fr_im[N];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int idx, input int re, input int im, input int tol);
    exp_t e;
    e.idx = idx; e.re = re; e.im = im; e.tol = tol;
    exp_q.push_back(e);
  endtask

  // Monitor: peeks the head every out_valid cycle (checks hold under stall), pops on accept.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && in_valid && in_ready && first_acc < 0) first_acc = cyc;
    if (out_valid) begin
      if (first_out < 0) first_out = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: idx=%0d re=%0d im=%0d", out_idx, out_re, out_im);
      end else begin
        e = exp_q[0];
        if (int'(out_idx) != e.idx || iabs(int'(out_re) - e.re) > e.tol ||
            iabs(int'(out_im) - e.im) > e.tol || out_last !== (e.idx == N - 1)) begin
          bad++;
          $display("FAIL bin: got idx=%0d re=%0d im=%0d last=%0b expected idx=%0d re=%0d im=%0d tol=%0d",
                   out_idx, out_re, out_im, out_last, e.idx, e.re, e.im, e.tol);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_frame(input int re0, input int im0, input int re_rest, input int ramp);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = (ramp != 0) ? i + 1 : ((i == 0) ? re0 : re_rest);
      fr_im[i] = (i == 0) ? im0 : 0;
    end
  endtask

  task automatic send_frame(input bit gaps, input bit junk_after);
    bit ok;
    int guard;
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_re = 16'(fr_re[i]);
      in_im = 16'(fr_im[i]);
      guard = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!ok && guard < 60);
      if (!ok) begin
        total++; bad++;
        $display("FAIL load_timeout: sample %0d not accepted", i);
      end
    end
    in_valid = 1'b0;
    if (junk_after) begin
      in_valid = 1'b1;
      in_re = 16'sd999;
      in_im = -16'sd999;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d bins outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    @(posedge clk);
    #1;

    // Impulse, continuous input; also measures first-accept to first-valid.
    set_frame(1000, 0, 0, 0);
    for (int k = 0; k < N; k++) push_exp(k, IMP_RE, 0, 0);
    send_frame(1'b0, 1'b0);
    drain();
    chk("latency_cycles", first_out - first_acc + 1, N + 3 * N / 2 + 1);

    // Constant input with in_valid gaps.
    set_frame(100, 0, 100, 0);
    for (int k = 0; k < N; k++) push_exp(k, (k == 0) ? CONST_X0 : 0, 0, 0);
    send_frame(1'b1, 1'b0);
    drain();

`ifndef FFT_STAGE_SCALE_EN
    // Ramp 1..8 with a 5-cycle stall at bin 3.
    set_frame(0, 0, 0, 1);
    push_exp(0, 36, 0, 0);   push_exp(1, -4, 10, 2);
    push_exp(2, -4, 4, 2);   push_exp(3, -4, 2, 2);
    push_exp(4, -4, 0, 0);   push_exp(5, -4, -2, 2);
    push_exp(6, -4, -4, 2);  push_exp(7, -4, -10, 2);
    send_frame(1'b0, 1'b0);
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!(out_valid && out_idx == 3'd3) && guard < 100);
    chk("stall_reached_bin3", int'(out_idx), 3);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
`endif

    // Imaginary impulse; in_valid held during compute must be ignored.
    set_frame(0, 500, 0, 0);
    for (int k = 0; k < N; k++) push_exp(k, 0, IMAG_IM, 0);
    send_frame(1'b0, 1'b1);
    drain();

    // Large constant: DC bin wraps when unscaled.
    set_frame(20000, 0, 20000, 0);
    for (int k = 0; k < N; k++) push_exp(k, (k == 0) ? WRAP_X0 : 0, 0, 0);
    send_frame(1'b0, 1'b0);
    drain();

    // Abort at compute cycle 6, then a fresh impulse frame.
    set_frame(0, 0, 0, 1);
    send_frame(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_mid_compute", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    set_frame(1000, 0, 0, 0);
    for (int k = 0; k < N; k++) push_exp(k, IMP_RE, 0, 0);
    send_frame(1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
